regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two write-back sources:

---
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin merge of two write-back FIFOs onto one register-file write port
// Ports: Clk, Rst (synchronous, active-high)
//        ReqValidA/ReqReadyA/ReqRegA/ReqDataA  port A (ALU) push interface
//        ReqValidB/ReqReadyB/ReqRegB/ReqDataB  port B (load) push interface
//        RegWrite/WriteRegister/WriteData      registered register-file write stage
//        Idle                                  nothing queued and no write in flight
// Build option HAZARD_CHECK_EN adds ReadRegister1/2 inputs and combinational Pending1/2 outputs.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqValidA,
  output logic                  ReqReadyA,
  input  logic [ADDR_WIDTH-1:0] ReqRegA,
  input  logic [DATA_WIDTH-1:0] ReqDataA,
  input  logic                  ReqValidB,
  output logic                  ReqReadyB,
  input  logic [ADDR_WIDTH-1:0] ReqRegB,
  input  logic [DATA_WIDTH-1:0] ReqDataB,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Idle
`ifdef HAZARD_CHECK_EN
  ,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic                  Pending1,
  output logic                  Pending2
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [1:0] valid, ready, push, ne, grant;
  logic [1:0][ADDR_WIDTH-1:0] req_reg, head_reg;
  logic [1:0][DATA_WIDTH-1:0] req_data, head_data;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic last_b;
`ifdef HAZARD_CHECK_EN
  logic [1:0] hit1, hit2;
`endif
  assign valid     = {ReqValidB, ReqValidA};
  assign req_reg   = {ReqRegB, ReqRegA};
  assign req_data  = {ReqDataB, ReqDataA};
  assign ReqReadyA = ready[0];
  assign ReqReadyB = ready[1];
  // index 0 is port A, index 1 is port B
  for (genvar p = 0; p < 2; p++) begin : g_fifo
    logic [ADDR_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    // ready comes from the registered count only, so a full FIFO stays closed even while popping
    assign ready[p]     = cnt != CW'(DEPTH);
    assign ne[p]        = cnt != '0;
    assign push[p]      = valid[p] && ready[p];
    assign head_reg[p]  = mem_reg[rd];
    assign head_data[p] = mem_data[rd];
    always_ff @(posedge Clk) begin
      if (push[p]) begin
        mem_reg[wr]  <= req_reg[p];
        mem_data[wr] <= req_data[p];
      end
    end
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge Clk) begin
      if (Rst) begin
        rd  <= '0;
        wr  <= '0;
        cnt <= '0;
      end else begin
        rd  <= rd + PW'(grant[p]);
        wr  <= wr + PW'(push[p]);
        cnt <= cnt + CW'(push[p]) - CW'(grant[p]);
      end
    end
`ifdef HAZARD_CHECK_EN
    logic [PW-1:0] off;
    logic h1, h2;
    // a slot is live when its distance from the read pointer is below the count
    always_comb begin
      h1  = 1'b0;
      h2  = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rd;
        if (CW'(off) < cnt) begin
          h1 = h1 | (mem_reg[i] == ReadRegister1);
          h2 = h2 | (mem_reg[i] == ReadRegister2);
        end
      end
    end
    assign hit1[p] = h1;
    assign hit2[p] = h2;
`endif
  end
  // last_b=1 means B won the last contention, so A takes the next one
  assign grant[0] = ne[0] && (!ne[1] || last_b);
  assign grant[1] = ne[1] && !grant[0];
  assign sel_reg  = grant[1] ? head_reg[1] : head_reg[0];
  assign sel_data = grant[1] ? head_data[1] : head_data[0];
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      last_b        <= 1'b1;
    end else begin
      // register-0 entries still pop and load the stage, they just never assert the write
      RegWrite <= |grant && (sel_reg != '0);
      if (|grant) begin
        WriteRegister <= sel_reg;
        WriteData     <= sel_data;
      end
      if (&ne) last_b <= grant[1];
    end
  end
  assign Idle = !(|ne) && !RegWrite;
`ifdef HAZARD_CHECK_EN
  assign Pending1 = (ReadRegister1 != '0) && (|hit1 || (RegWrite && WriteRegister == ReadRegister1));
  assign Pending2 = (ReadRegister2 != '0) && (|hit2 || (RegWrite && WriteRegister == ReadRegister2));
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic ReqValidA = 1'b0, ReqValidB = 1'b0;
  logic ReqReadyA, ReqReadyB;
  logic [AW-1:0] ReqRegA = '0, ReqRegB = '0;
  logic [DW-1:0] ReqDataA = '0, ReqDataB = '0;
  logic RegWrite, Idle;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
`ifdef HAZARD_CHECK_EN
  logic [AW-1:0] ReadRegister1 = '0, ReadRegister2 = '0;
  logic Pending1, Pending2;
`endif
  always #5 Clk = ~Clk;
  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValidA(ReqValidA), .ReqReadyA(ReqReadyA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA),
    .ReqValidB(ReqValidB), .ReqReadyB(ReqReadyB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData), .Idle(Idle)
`ifdef HAZARD_CHECK_EN
    , .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Pending1(Pending1), .Pending2(Pending2)
`endif
  );
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;
  typedef struct {
    logic va; logic [AW-1:0] ra; logic [DW-1:0] da;
    logic vb; logic [AW-1:0] rb; logic [DW-1:0] db;
    logic we; logic [AW-1:0] wr; logic [DW-1:0] wd;
    logic rdy_a; logic rdy_b; logic idle;
  } vec_t;
  ent_t qa[$], qb[$];
  bit last_b = 1'b1;
  bit m_we = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [AW-1:0] wq[$];
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit pend(input logic [AW-1:0] rr);
    if (rr == '0) return 1'b0;
    foreach (qa[i]) if (qa[i].r == rr) return 1'b1;
    foreach (qb[i]) if (qb[i].r == rr) return 1'b1;
    return m_we && m_wr == rr;
  endfunction
  task automatic check_all();
    check("ready_a", ReqReadyA, qa.size() != DEPTH);
    check("ready_b", ReqReadyB, qb.size() != DEPTH);
    check("reg_write", RegWrite, m_we);
    check("write_reg", WriteRegister, m_wr);
    check("write_data", WriteData, m_wd);
    check("idle", Idle, qa.size() == 0 && qb.size() == 0 && !m_we);
`ifdef HAZARD_CHECK_EN
    check("pending1", Pending1, pend(ReadRegister1));
    check("pending2", Pending2, pend(ReadRegister2));
`endif
  endtask
  task automatic drive(input logic va, input logic [AW-1:0] ra, input logic [DW-1:0] da,
                       input logic vb, input logic [AW-1:0] rb, input logic [DW-1:0] db);
    ReqValidA = va; ReqRegA = ra; ReqDataA = da;
    ReqValidB = vb; ReqRegB = rb; ReqDataB = db;
  endtask
  // advance the model by one clock edge from the current inputs, then compare the DUT
  task automatic tick();
    ent_t e;
    bit acc_a, acc_b, ga, gb;
    if (Rst) begin
      qa.delete(); qb.delete();
      last_b = 1'b1; m_we = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      acc_a = ReqValidA && qa.size() != DEPTH;
      acc_b = ReqValidB && qb.size() != DEPTH;
      if (qa.size() > 0 && qb.size() > 0) begin
        ga = last_b;
        gb = !last_b;
        last_b = gb;
      end else begin
        ga = qa.size() > 0;
        gb = qb.size() > 0;
      end
      e = '{r: '0, d: '0};
      if (ga) e = qa.pop_front();
      if (gb) e = qb.pop_front();
      m_we = (ga || gb) && e.r != '0;
      if (ga || gb) begin
        m_wr = e.r;
        m_wd = e.d;
      end
      if (acc_a) qa.push_back('{r: ReqRegA, d: ReqDataA});
      if (acc_b) qb.push_back('{r: ReqRegB, d: ReqDataB});
    end
    @(posedge Clk);
    #1;
    check_all();
  endtask
  task automatic tick_cap();
    tick();
    if (RegWrite) wq.push_back(WriteRegister);
  endtask
  task automatic do_reset();
    Rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    Rst = 1'b0;
  endtask
  vec_t tbl[12];
  logic [AW-1:0] exp_order[5];
  initial begin
    tbl[0]  = '{1, 1, 'h101, 1, 3, 'h103, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{1, 2, 'h102, 1, 4, 'h104, 1, 1, 'h101, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 3, 'h103, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 2, 'h102, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 4, 'h104, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 4, 'h104, 1, 1, 1};
    tbl[6]  = '{1, 5, 'hDEADBEEF, 0, 0, 0, 0, 4, 'h104, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 5, 'hDEADBEEF, 1, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 5, 'hDEADBEEF, 1, 1, 1};
    tbl[9]  = '{1, 0, 'h1234, 0, 0, 0, 0, 5, 'hDEADBEEF, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 'h1234, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 'h1234, 1, 1, 1};
    exp_order = '{5'd1, 5'd3, 5'd2, 5'd4, 5'd7};
    // reset held two cycles
    Rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_reg_write", RegWrite, 0);
    check("rst_ready_a", ReqReadyA, 1);
    check("rst_ready_b", ReqReadyB, 1);
    check("rst_idle", Idle, 1);
    Rst = 1'b0;
    // directed table: contention order, single write latency, register-0 discard
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].va, tbl[i].ra, tbl[i].da, tbl[i].vb, tbl[i].rb, tbl[i].db);
      tick();
      check($sformatf("row%0d_we", i), RegWrite, tbl[i].we);
      check($sformatf("row%0d_wr", i), WriteRegister, tbl[i].wr);
      check($sformatf("row%0d_wd", i), WriteData, tbl[i].wd);
      check($sformatf("row%0d_rdy_a", i), ReqReadyA, tbl[i].rdy_a);
      check($sformatf("row%0d_rdy_b", i), ReqReadyB, tbl[i].rdy_b);
      check($sformatf("row%0d_idle", i), Idle, tbl[i].idle);
    end
    // full B FIFO refuses a push until a pop frees a slot
    do_reset();
    wq.delete();
    drive(1, 1, 'h101, 1, 3, 'h103);
    tick_cap();
    drive(1, 2, 'h102, 1, 4, 'h104);
    tick_cap();
    check("full_ready_b", ReqReadyB, 0);
    drive(0, 0, 0, 1, 7, 'h107);
    tick_cap();
    check("refill_ready_b", ReqReadyB, 1);
    tick_cap();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick_cap();
    check("order_len", wq.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("order%0d", i), (i < wq.size()) ? wq[i] : 'x, exp_order[i]);
    // reset with three entries pending
    do_reset();
    drive(1, 1, 'h11, 1, 3, 'h33);
    tick();
    drive(1, 2, 'h22, 1, 4, 'h44);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_CHECK_EN
    ReadRegister1 = 5'd4;
    #1;
    check("pend_before_rst", Pending1, 1);
`endif
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rst_mid_we", RegWrite, 0);
    check("rst_mid_idle", Idle, 1);
`ifdef HAZARD_CHECK_EN
    check("pend_after_rst", Pending1, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_mid_quiet%0d", i), RegWrite, 0);
    end
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      Rst = ($urandom_range(99) == 0);
      drive($urandom_range(9) < 6, AW'($urandom_range(7)), $urandom(),
            $urandom_range(9) < 6, AW'($urandom_range(7)), $urandom());
`ifdef HAZARD_CHECK_EN
      ReadRegister1 = AW'($urandom_range(7));
      ReadRegister2 = AW'($urandom_range(7));
`endif
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
